// File: rtl/controle_multiciclo_if.sv
// controle_multiciclo_if: IR fields, ALU flags and datapath control lines between controller and datapath
interface controle_multiciclo_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic [1:0] src_pc;
  logic       ula_src_a;
  logic [1:0] ula_src_b;
  logic [2:0] ula_op;
  logic       reg_dst;
  logic [1:0] mem2reg;
  logic       esc_reg;
  logic       iord;
  logic       mem_wr;
  logic       ir_load;
  logic       mdr_load;
  logic       alu_out_wr;
  logic       pc_wr;
  logic       pc_wr_cond;
  logic       cond_ne;
  logic       epc_wr;
  logic [1:0] cause;
  logic [3:0] estado;
  modport master (
    input  opcode, funct, zero, overflow,
    output src_pc, ula_src_a, ula_src_b, ula_op, reg_dst, mem2reg, esc_reg, iord, mem_wr,
           ir_load, mdr_load, alu_out_wr, pc_wr, pc_wr_cond, cond_ne, epc_wr, cause, estado
  );
  modport slave (
    output opcode, funct, zero, overflow,
    input  src_pc, ula_src_a, ula_src_b, ula_op, reg_dst, mem2reg, esc_reg, iord, mem_wr,
           ir_load, mdr_load, alu_out_wr, pc_wr, pc_wr_cond, cond_ne, epc_wr, cause, estado
  );
endinterface

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle MIPS-subset control FSM with memory wait states and exceptions
module controle_multiciclo #(
  parameter int MEM_WAIT = 2
) (
  input logic clock,
  input logic reset,
  controle_multiciclo_if.master bus
);
  typedef enum logic [3:0] {
    RST, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R,
    R_WB, EXEC_I, I_WB, LUI_WB, BRANCH, JUMP, EXC
  } state_t;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       last, mem, r_ok, r_arith, unused_zero;
  assign last        = cnt_q == 3'(MEM_WAIT);
  assign mem         = state_q inside {FETCH, MEM_READ, MEM_WRITE};
  assign r_ok        = bus.funct inside {6'h20, 6'h22, 6'h24};
  assign r_arith     = bus.funct != 6'h24;
  assign cnt_d       = (mem && !last) ? cnt_q + 3'd1 : 3'd0;
  assign unused_zero = bus.zero;
  assign bus.cause   = cause_q;
  assign bus.estado  = state_q;
  // state, wait counter and exception cause registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RST;
      cnt_q   <= 3'd0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end
  // next state; cause is loaded on the transition into EXC
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      RST:       state_d = FETCH;
      FETCH:     state_d = last ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          6'h23, 6'h2B: state_d = MEM_ADDR;
          6'h00:        state_d = r_ok ? EXEC_R : EXC;
          6'h04, 6'h05: state_d = BRANCH;
          6'h02:        state_d = JUMP;
          6'h08:        state_d = EXEC_I;
          6'h0F:        state_d = LUI_WB;
          default:      state_d = EXC;
        endcase
        cause_d = (state_d == EXC) ? 2'b01 : cause_q;
      end
      MEM_ADDR:  state_d = (bus.opcode == 6'h2B) ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_d = last ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = last ? FETCH : MEM_WRITE;
      EXEC_R: begin
        state_d = (bus.overflow && r_arith) ? EXC : R_WB;
        cause_d = (bus.overflow && r_arith) ? 2'b10 : cause_q;
      end
      EXEC_I: begin
        state_d = bus.overflow ? EXC : I_WB;
        cause_d = bus.overflow ? 2'b10 : cause_q;
      end
      MEM_WB, R_WB, I_WB, LUI_WB, BRANCH, JUMP, EXC: state_d = FETCH;
      default:   state_d = RST;
    endcase
  end
  // Moore control outputs decoded from state and wait counter
  always_comb begin
    bus.src_pc     = 2'b00;
    bus.ula_src_a  = 1'b0;
    bus.ula_src_b  = 2'b00;
    bus.ula_op     = 3'b000;
    bus.reg_dst    = 1'b0;
    bus.mem2reg    = 2'b00;
    bus.esc_reg    = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.ir_load    = 1'b0;
    bus.mdr_load   = 1'b0;
    bus.alu_out_wr = 1'b0;
    bus.pc_wr      = 1'b0;
    bus.pc_wr_cond = 1'b0;
    bus.cond_ne    = 1'b0;
    bus.epc_wr     = 1'b0;
    case (state_q)
      FETCH: begin
        bus.ir_load   = last;
        bus.pc_wr     = last;
        bus.ula_src_b = last ? 2'b01 : 2'b00;
        bus.ula_op    = last ? 3'b001 : 3'b000;
      end
      DECODE: begin
        bus.ula_src_b  = 2'b11;
        bus.ula_op     = 3'b001;
        bus.alu_out_wr = 1'b1;
      end
      MEM_ADDR, EXEC_I: begin
        bus.ula_src_a  = 1'b1;
        bus.ula_src_b  = 2'b10;
        bus.ula_op     = 3'b001;
        bus.alu_out_wr = 1'b1;
      end
      MEM_READ: begin
        bus.iord     = 1'b1;
        bus.mdr_load = last;
      end
      MEM_WB: begin
        bus.mem2reg = 2'b01;
        bus.esc_reg = 1'b1;
      end
      MEM_WRITE: begin
        bus.iord   = 1'b1;
        bus.mem_wr = 1'b1;
      end
      EXEC_R: begin
        bus.ula_src_a  = 1'b1;
        bus.ula_op     = (bus.funct == 6'h20) ? 3'b001 : (bus.funct == 6'h22) ? 3'b010 : 3'b011;
        bus.alu_out_wr = 1'b1;
      end
      R_WB: begin
        bus.reg_dst = 1'b1;
        bus.esc_reg = 1'b1;
      end
      I_WB:      bus.esc_reg = 1'b1;
      LUI_WB: begin
        bus.mem2reg = 2'b10;
        bus.esc_reg = 1'b1;
      end
      BRANCH: begin
        bus.ula_src_a  = 1'b1;
        bus.ula_op     = 3'b010;
        bus.pc_wr_cond = 1'b1;
        bus.src_pc     = 2'b01;
        bus.cond_ne    = bus.opcode == 6'h05;
      end
      JUMP: begin
        bus.src_pc = 2'b10;
        bus.pc_wr  = 1'b1;
      end
      EXC: begin
        bus.ula_src_b = 2'b01;
        bus.ula_op    = 3'b010;
        bus.epc_wr    = 1'b1;
        bus.src_pc    = 2'b11;
        bus.pc_wr     = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: instruction-level sequence model checked cycle by cycle on two wait-state settings
module tb_controle_multiciclo;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst0 = 1'b1, rst1 = 1'b1;
  controle_multiciclo_if bus0 ();
  controle_multiciclo_if bus1 ();
  controle_multiciclo #(.MEM_WAIT(2)) u0 (.clock(clock), .reset(rst0), .bus(bus0));
  controle_multiciclo #(.MEM_WAIT(0)) u1 (.clock(clock), .reset(rst1), .bus(bus1));
  localparam logic [9:0] F_ESC = 10'h200, F_IORD = 10'h100, F_MW = 10'h080, F_IR = 10'h040,
                         F_MDR = 10'h020, F_AO = 10'h010, F_PW = 10'h008, F_PWC = 10'h004,
                         F_NE = 10'h002, F_EPC = 10'h001;
  logic [22:0] act [2];
  logic [22:0] expw [2];
  logic        ev [2];
  logic [1:0]  cause_m [2];
  logic [1:0]  cause_nxt;
  logic [22:0] q [$];
  int checks = 0, fails = 0;
  assign act[0] = {bus0.src_pc, bus0.ula_src_a, bus0.ula_src_b, bus0.ula_op, bus0.reg_dst, bus0.mem2reg,
                   bus0.esc_reg, bus0.iord, bus0.mem_wr, bus0.ir_load, bus0.mdr_load, bus0.alu_out_wr,
                   bus0.pc_wr, bus0.pc_wr_cond, bus0.cond_ne, bus0.epc_wr, bus0.cause};
  assign act[1] = {bus1.src_pc, bus1.ula_src_a, bus1.ula_src_b, bus1.ula_op, bus1.reg_dst, bus1.mem2reg,
                   bus1.esc_reg, bus1.iord, bus1.mem_wr, bus1.ir_load, bus1.mdr_load, bus1.alu_out_wr,
                   bus1.pc_wr, bus1.pc_wr_cond, bus1.cond_ne, bus1.epc_wr, bus1.cause};
  function automatic logic [22:0] w(input logic [1:0] sp, input logic a, input logic [1:0] b,
                                    input logic [2:0] op, input logic rd, input logic [1:0] m2r,
                                    input logic [9:0] f, input logic [1:0] c);
    return {sp, a, b, op, rd, m2r, f, c};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic build(input int d, input logic [5:0] op, input logic [5:0] fn, input logic ovf);
    int n;
    logic [1:0] c;
    n = (d == 0) ? 3 : 1;
    c = cause_m[d];
    q.delete();
    for (int i = 0; i < n; i++)
      q.push_back(i == n - 1 ? w(2'd0, 1'b0, 2'd1, 3'd1, 1'b0, 2'd0, F_IR | F_PW, c)
                             : w(2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 10'h0, c));
    q.push_back(w(2'd0, 1'b0, 2'd3, 3'd1, 1'b0, 2'd0, F_AO, c));
    if (op == 6'h23 || op == 6'h2B) begin
      q.push_back(w(2'd0, 1'b1, 2'd2, 3'd1, 1'b0, 2'd0, F_AO, c));
      if (op == 6'h23) begin
        for (int i = 0; i < n; i++)
          q.push_back(w(2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, F_IORD | (i == n - 1 ? F_MDR : 10'h0), c));
        q.push_back(w(2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd1, F_ESC, c));
      end else
        for (int i = 0; i < n; i++) q.push_back(w(2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, F_IORD | F_MW, c));
    end else if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      q.push_back(w(2'd0, 1'b1, 2'd0, fn == 6'h20 ? 3'd1 : fn == 6'h22 ? 3'd2 : 3'd3, 1'b0, 2'd0, F_AO, c));
      if (ovf && fn != 6'h24) begin
        c = 2'd2;
        q.push_back(w(2'd3, 1'b0, 2'd1, 3'd2, 1'b0, 2'd0, F_PW | F_EPC, c));
      end else q.push_back(w(2'd0, 1'b0, 2'd0, 3'd0, 1'b1, 2'd0, F_ESC, c));
    end else if (op == 6'h08) begin
      q.push_back(w(2'd0, 1'b1, 2'd2, 3'd1, 1'b0, 2'd0, F_AO, c));
      if (ovf) begin
        c = 2'd2;
        q.push_back(w(2'd3, 1'b0, 2'd1, 3'd2, 1'b0, 2'd0, F_PW | F_EPC, c));
      end else q.push_back(w(2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, F_ESC, c));
    end else if (op == 6'h0F) q.push_back(w(2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd2, F_ESC, c));
    else if (op == 6'h04 || op == 6'h05)
      q.push_back(w(2'd1, 1'b1, 2'd0, 3'd2, 1'b0, 2'd0, F_PWC | (op == 6'h05 ? F_NE : 10'h0), c));
    else if (op == 6'h02) q.push_back(w(2'd2, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, F_PW, c));
    else begin
      c = 2'd1;
      q.push_back(w(2'd3, 1'b0, 2'd1, 3'd2, 1'b0, 2'd0, F_PW | F_EPC, c));
    end
    cause_nxt = c;
  endtask
  task automatic step(input int d, input logic [22:0] e);
    expw[d] = e;
    ev[d] = 1'b1;
    if (d == 0) bus0.zero = 1'($urandom);
    else bus1.zero = 1'($urandom);
    @(posedge clock);
    #1;
  endtask
  task automatic run(input int d, input logic [5:0] op, input logic [5:0] fn, input logic ovf, input int lim);
    build(d, op, fn, ovf);
    cause_m[d] = cause_nxt;
    if (d == 0) begin
      bus0.opcode = op; bus0.funct = fn; bus0.overflow = ovf;
    end else begin
      bus1.opcode = op; bus1.funct = fn; bus1.overflow = ovf;
    end
    for (int k = 0; q.size() > 0 && (lim < 0 || k < lim); k++) step(d, q.pop_front());
  endtask
  task automatic do_reset(input int d);
    if (d == 0) rst0 = 1'b1;
    else rst1 = 1'b1;
    cause_m[d] = 2'd0;
    step(d, 23'h0);
    step(d, 23'h0);
    if (d == 0) rst0 = 1'b0;
    else rst1 = 1'b0;
    step(d, 23'h0);
  endtask
  initial forever begin
    @(negedge clock);
    for (int d = 0; d < 2; d++)
      if (ev[d]) begin
        checks++;
        if (act[d] !== expw[d]) begin
          fails++;
          $display("FAIL cycle dut%0d t=%0t got %h want %h", d, $time, act[d], expw[d]);
        end
      end
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    ev[0] = 1'b0; ev[1] = 1'b0;
    bus0.opcode = 6'h0; bus0.funct = 6'h0; bus0.zero = 1'b0; bus0.overflow = 1'b0;
    bus1.opcode = 6'h0; bus1.funct = 6'h0; bus1.zero = 1'b0; bus1.overflow = 1'b0;
    @(posedge clock);
    #1;
    do_reset(0);
    build(0, 6'h23, 6'h00, 1'b0);
    chk("lw_len", q.size(), 9);
    chk("lw_ir_c3", q[2][8], 1);
    chk("lw_mdr_c8", q[7][7], 1);
    chk("lw_esc_c9", q[8][11], 1);
    chk("lw_m2r_c9", q[8][13:12], 1);
    run(0, 6'h23, 6'h00, 1'b0, -1);
    build(0, 6'h00, 6'h20, 1'b1);
    chk("ovf_len", q.size(), 6);
    chk("ovf_exc", {q[5][22:21], q[5][2], q[5][1:0]}, 5'b11110);
    run(0, 6'h00, 6'h20, 1'b1, -1);
    build(0, 6'h3F, 6'h00, 1'b0);
    chk("inv_len", q.size(), 5);
    chk("inv_cause_pw", {q[4][1:0], q[4][5]}, 3'b011);
    run(0, 6'h3F, 6'h00, 1'b0, -1);
    build(0, 6'h05, 6'h00, 1'b0);
    chk("bne_word", {q[4][22:21], q[4][4], q[4][3]}, 4'b0111);
    run(0, 6'h05, 6'h00, 1'b0, -1);
    run(0, 6'h04, 6'h00, 1'b1, -1);
    run(0, 6'h00, 6'h22, 1'b0, -1);
    run(0, 6'h00, 6'h24, 1'b1, -1);
    run(0, 6'h08, 6'h00, 1'b0, -1);
    run(0, 6'h08, 6'h00, 1'b1, -1);
    run(0, 6'h02, 6'h00, 1'b1, -1);
    run(0, 6'h0F, 6'h00, 1'b1, -1);
    run(0, 6'h00, 6'h25, 1'b0, -1);
    run(0, 6'h00, 6'h22, 1'b1, -1);
    run(0, 6'h2B, 6'h00, 1'b1, -1);
    run(0, 6'h2B, 6'h00, 1'b0, 6);
    chk("mw_pre_rst", act[0][9], 1);
    #1 rst0 = 1'b1;
    #1;
    chk("mw_rst", act[0][9], 0);
    chk("esc_rst", act[0][11], 0);
    do_reset(0);
    run(0, 6'h23, 6'h00, 1'b0, -1);
    ev[0] = 1'b0;
    do_reset(1);
    build(1, 6'h2B, 6'h00, 1'b0);
    chk("sw0_len", q.size(), 4);
    chk("sw0_mw_iord", {q[3][10], q[3][9]}, 2'b11);
    chk("sw0_no_esc", {q[0][11], q[1][11], q[2][11], q[3][11]}, 4'b0000);
    run(1, 6'h2B, 6'h00, 1'b0, -1);
    run(1, 6'h23, 6'h00, 1'b0, -1);
    run(1, 6'h00, 6'h22, 1'b1, -1);
    run(1, 6'h0F, 6'h00, 1'b0, -1);
    run(1, 6'h2B, 6'h00, 1'b0, -1);
    ev[1] = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle control FSM that sequences the single-memory MIPS-subset datapath: PC, shared instruction/data memory, IR, MDR, register bank, ALUOut, ALU and their muxes.
- Decodes the IR opcode/funct and drives every mux select and write enable, one state per datapath step.
- Inserts parameterised memory wait states on every memory access.
- Handles invalid-opcode and arithmetic-overflow exceptions by saving EPC and redirecting the PC to a fixed vector.

Parameters:
- MEM_WAIT, 2: extra wait cycles per memory access (0..7); every memory state lasts MEM_WAIT+1 cycles.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU overflow flag
- src_pc  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector
- ula_src_a  out  1  0 = PC, 1 = reg A
- ula_src_b  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2
- ula_op  out  3  000 pass A, 001 add, 010 sub, 011 and
- reg_dst  out  1  0 = rt, 1 = rd
- mem2reg  out  2  00 ALUOut, 01 MDR, 10 imm<<16
- esc_reg  out  1  register-bank write
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_wr  out  1  memory write (0 = read)
- ir_load  out  1  IR load
- mdr_load  out  1  MDR load
- alu_out_wr  out  1  ALUOut load
- pc_wr  out  1  unconditional PC write
- pc_wr_cond  out  1  conditional PC write
- cond_ne  out  1  1 = branch on !zero (BNE), 0 = branch on zero
- epc_wr  out  1  EPC load
- cause  out  2  00 none, 01 invalid opcode, 10 overflow; held until the next exception
- estado  out  4  current state encoding, for debug

Behaviour:
- Moore outputs, decoded from state and wait counter. Any output not listed for a state is 0.
- Reset: async entry to RST; all outputs 0; cause 00; counter 0. RST lasts 1 cycle after reset deasserts, then goes to FETCH.
- Wait counter (3 bits): cleared on entry to each memory state; counts 0..MEM_WAIT. The state exits when count == MEM_WAIT.
- FETCH: iord=0, mem_wr=0. On the final cycle only: ir_load=1, ula_src_a=0, ula_src_b=01, ula_op=001, src_pc=00, pc_wr=1. Next state: DECODE.
- DECODE: ula_src_a=0, ula_src_b=11, ula_op=001, alu_out_wr=1 (branch target). Dispatch on opcode:
  - 0x23 / 0x2B -> MEM_ADDR
  - 0x00 with funct 0x20 / 0x22 / 0x24 -> EXEC_R
  - 0x04 / 0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> EXEC_I
  - 0x0F -> LUI_WB
  - anything else, including an unsupported R funct -> EXC, cause=01
- MEM_ADDR: ula_src_a=1, ula_src_b=10, op add, alu_out_wr=1. Next: MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: iord=1. mdr_load=1 on the final cycle. Next: MEM_WB.
- MEM_WB: mem2reg=01, reg_dst=0, esc_reg=1. Next: FETCH.
- MEM_WRITE: iord=1, mem_wr=1 for all MEM_WAIT+1 cycles. Next: FETCH.
- EXEC_R: ula_src_a=1, ula_src_b=00, alu_out_wr=1, op from funct (0x20 add, 0x22 sub, 0x24 and).
  - overflow=1 with add/sub -> EXC, cause=10.
  - Otherwise -> R_WB.
- R_WB: reg_dst=1, mem2reg=00, esc_reg=1. Next: FETCH.
- EXEC_I: ula_src_a=1, ula_src_b=10, op add, alu_out_wr=1.
  - overflow=1 -> EXC, cause=10.
  - Otherwise -> I_WB.
- I_WB: reg_dst=0, mem2reg=00, esc_reg=1. Next: FETCH.
- LUI_WB: reg_dst=0, mem2reg=10, esc_reg=1. Next: FETCH.
- BRANCH: ula_src_a=1, ula_src_b=00, op sub, pc_wr_cond=1, src_pc=01; cond_ne=1 for 0x05. The datapath gates the PC write with the zero flag. Next: FETCH.
- JUMP: src_pc=10, pc_wr=1. Next: FETCH.
- EXC (1 cycle):
  - ula_src_a=0, ula_src_b=01, op sub: PC-4, the faulting instruction address. epc_wr=1.
  - src_pc=11, pc_wr=1.
  - The cause register updates on entry.
  - No esc_reg and no mem_wr in this state, so the offending write never occurs.
  - Next: FETCH.
- Cycle counts (instruction start to first FETCH cycle, F = MEM_WAIT+1):
  - LW: F+3+F
  - SW: F+2+F
  - R-type, ADDI: F+3
  - BEQ/BNE, J, LUI: F+2
  - exception: F+2 (invalid opcode) or F+3 (overflow)
- Overflow is ignored for AND and in every state except EXEC_R and EXEC_I.
- Reset asserted mid-instruction forces RST immediately. Pending writes are dropped: mem_wr and esc_reg fall to 0 asynchronously.

Test Plan:
- MEM_WAIT=2, LW (0x23) -> FETCH 3 cycles with ir_load/pc_wr on the 3rd; mdr_load on cycle 8; esc_reg=1 with mem2reg=01 on cycle 9; FETCH on cycle 10.
- SW (0x2B), MEM_WAIT=0 -> mem_wr=1 and iord=1 for exactly 1 cycle; esc_reg stays 0 throughout.
- R add (funct 0x20) with overflow=1 in EXEC_R -> EXC next cycle: epc_wr=1, src_pc=11, cause=10; esc_reg never asserted.
- Opcode 0x3F -> DECODE then EXC: cause=01, pc_wr=1, then FETCH.
- BNE (0x05) -> BRANCH with pc_wr_cond=1, cond_ne=1, src_pc=01; BEQ gives cond_ne=0.
- Reset pulsed during MEM_WRITE wait cycle 1 -> mem_wr=0 immediately; RST for 1 cycle after release; then FETCH with counter restarted at 0.
